// File: rtl/battleship_pkg.sv
// Shared definitions for the placement controller.
// Contents:
//   - Board geometry: BOARD_DIM, CELLS.
//   - Fleet description: NUM_SHIPS, MAX_LEN, SHIP_LEN.
//   - One-hot orientation codes: NORTH, EAST, SOUTH, WEST.
//   - FSM state encoding: state_t.
//   - Helpers: ship_len(), rot_cw(), cell_idx().
package battleship_pkg;

  localparam int BOARD_DIM = 10;
  localparam int NUM_SHIPS = 5;
  localparam int MAX_LEN   = 5;
  localparam int CELLS     = BOARD_DIM * BOARD_DIM;
  localparam int ID_W      = 3;

  localparam logic [3:0] SHIP_LEN [NUM_SHIPS] = '{4'd5, 4'd4, 4'd3, 4'd3, 4'd2};

  localparam logic [3:0] NORTH = 4'b0001;
  localparam logic [3:0] EAST  = 4'b0010;
  localparam logic [3:0] SOUTH = 4'b0100;
  localparam logic [3:0] WEST  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Ship length for a fleet index; 0 for any index past the fleet.
  function automatic logic [3:0] ship_len(input logic [ID_W-1:0] idx);
    if (int'(idx) < NUM_SHIPS) return SHIP_LEN[idx];
    else return 4'd0;
  endfunction

  // Clockwise rotation of a one-hot N/E/S/W code is a 1-bit rotate left.
  function automatic logic [3:0] rot_cw(input logic [3:0] o);
    return {o[2:0], o[3]};
  endfunction

  // Linear occupancy index y*BOARD_DIM + x.
  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return ({3'b000, y} * 7'(BOARD_DIM)) + {3'b000, x};
  endfunction

endpackage

// File: rtl/ship_placer_if.sv
// Button / overlay / board-store bundle of the ship placement controller.
// Signals:
//   Buttons : start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place.
//   Overlay : cursor, orientation, length, fit_ok.
//   Store   : wr_en, wr_x, wr_y, wr_id.
//   Control : all_placed.
// Modports:
//   master : drives the buttons and observes the placer outputs.
//   slave  : the placer itself.
interface ship_placer_if;
  import battleship_pkg::*;

  logic            start;
  logic            btn_up;
  logic            btn_down;
  logic            btn_left;
  logic            btn_right;
  logic            btn_rotate;
  logic            btn_place;
  logic [7:0]      cursor;
  logic [3:0]      orientation;
  logic [3:0]      length;
  logic            fit_ok;
  logic            wr_en;
  logic [3:0]      wr_x;
  logic [3:0]      wr_y;
  logic [ID_W-1:0] wr_id;
  logic            all_placed;

  modport master (
    output start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place,
    input  cursor, orientation, length, fit_ok, wr_en, wr_x, wr_y, wr_id, all_placed
  );

  modport slave (
    input  start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place,
    output cursor, orientation, length, fit_ok, wr_en, wr_x, wr_y, wr_id, all_placed
  );

endinterface

// File: rtl/ship_cell_gen.sv
// Maps (anchor, orientation, offset k) to the k-th tile of a ship.
// Ports:
//   i_x, i_y    in  4  anchor tile
//   i_orient    in  4  one-hot N/E/S/W
//   i_k         in  3  cell offset along the ship
//   o_x, o_y    out 4  resulting tile (low bits; meaningful only when on board)
//   o_on_board  out 1  tile lies inside 0..BOARD_DIM-1 on both axes
module ship_cell_gen
  import battleship_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic [3:0] i_orient,
  input  logic [2:0] i_k,
  output logic [3:0] o_x,
  output logic [3:0] o_y,
  output logic       o_on_board
);

  localparam logic signed [4:0] W_DIM = 5'(BOARD_DIM);

  // 5-bit signed so that 0-k goes negative and 9+k does not wrap back on board.
  logic signed [4:0] w_sx;
  logic signed [4:0] w_sy;
  logic signed [4:0] w_k;

  always_comb begin
    w_k  = signed'({2'b00, i_k});
    w_sx = signed'({1'b0, i_x});
    w_sy = signed'({1'b0, i_y});
    case (i_orient)
      NORTH:   w_sy = w_sy - w_k;
      EAST:    w_sx = w_sx + w_k;
      SOUTH:   w_sy = w_sy + w_k;
      WEST:    w_sx = w_sx - w_k;
      default: ;
    endcase
  end

  assign o_x        = w_sx[3:0];
  assign o_y        = w_sy[3:0];
  assign o_on_board = (w_sx >= 5'sd0) && (w_sx < W_DIM) &&
                      (w_sy >= 5'sd0) && (w_sy < W_DIM);

endmodule

// File: rtl/ship_placer.sv
// Player-side fleet placement controller.
// Turns button pulses into the ghost-ship cursor/orientation/length, checks
// fit against an internal 100-bit occupancy map and commits each ship one
// cell per cycle to the board store, sequencing the fleet 5,4,3,3,2.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of ship_placer_if (buttons, overlay, store, all_placed)
module ship_placer
  import battleship_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ship_placer_if.slave bus
);

  state_t            r_state;
  logic [3:0]        r_x;
  logic [3:0]        r_y;
  logic [3:0]        r_orient;
  logic [3:0]        r_length;
  logic [ID_W-1:0]   r_ship_idx;
  logic [2:0]        r_k;
  logic [CELLS-1:0]  r_occ;
  logic              r_wr_en;
  logic [3:0]        r_wr_x;
  logic [3:0]        r_wr_y;
  logic [ID_W-1:0]   r_wr_id;
  logic              r_all_placed;

  // Fit check: every cell below the current length must be on board and free.
  logic [3:0]         w_fx [MAX_LEN];
  logic [3:0]         w_fy [MAX_LEN];
  logic [MAX_LEN-1:0] w_fon;
  logic [MAX_LEN-1:0] w_cell_ok;
  logic               w_fit_ok;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_fit
    ship_cell_gen u_fit_gen (
      .i_x        (r_x),
      .i_y        (r_y),
      .i_orient   (r_orient),
      .i_k        (3'(g)),
      .o_x        (w_fx[g]),
      .o_y        (w_fy[g]),
      .o_on_board (w_fon[g])
    );
    assign w_cell_ok[g] = (4'(g) >= r_length) ||
                          (w_fon[g] && !r_occ[cell_idx(w_fx[g], w_fy[g])]);
  end

  assign w_fit_ok = (r_length != 4'd0) && (&w_cell_ok);

  // Commit addressing looks one cell ahead: the accepting edge registers
  // cell 0, and each commit edge registers cell r_k+1.
  logic [2:0] w_ck;
  logic [3:0] w_cx;
  logic [3:0] w_cy;
  logic       w_con;

  assign w_ck = (r_state == S_COMMIT) ? (r_k + 3'd1) : 3'd0;

  ship_cell_gen u_commit_gen (
    .i_x        (r_x),
    .i_y        (r_y),
    .i_orient   (r_orient),
    .i_k        (w_ck),
    .o_x        (w_cx),
    .o_y        (w_cy),
    .o_on_board (w_con)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x          <= 4'd0;
      r_y          <= 4'd0;
      r_orient     <= NORTH;
      r_length     <= 4'd0;
      r_ship_idx   <= '0;
      r_k          <= 3'd0;
      r_occ        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_x       <= 4'd0;
      r_wr_y       <= 4'd0;
      r_wr_id      <= '0;
      r_all_placed <= 1'b0;
    end else if (bus.start) begin
      // start restarts from any state, including mid-commit.
      r_state      <= S_EDIT;
      r_x          <= 4'd0;
      r_y          <= 4'd0;
      r_orient     <= NORTH;
      r_ship_idx   <= '0;
      r_length     <= ship_len('0);
      r_k          <= 3'd0;
      r_occ        <= '0;
      r_wr_en      <= 1'b0;
      r_all_placed <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_EDIT: begin
          // One action per cycle, priority place > rotate > up > down > left > right.
          if (bus.btn_place) begin
            if (w_fit_ok) begin
              r_state <= S_COMMIT;
              r_k     <= 3'd0;
              r_wr_en <= 1'b1;
              r_wr_x  <= w_cx;
              r_wr_y  <= w_cy;
              r_wr_id <= r_ship_idx;
              if (w_con) r_occ[cell_idx(w_cx, w_cy)] <= 1'b1;
            end
          end else if (bus.btn_rotate) begin
            r_orient <= rot_cw(r_orient);
          end else if (bus.btn_up) begin
            r_y <= (r_y == 4'd0) ? 4'(BOARD_DIM - 1) : r_y - 4'd1;
          end else if (bus.btn_down) begin
            r_y <= (r_y == 4'(BOARD_DIM - 1)) ? 4'd0 : r_y + 4'd1;
          end else if (bus.btn_left) begin
            r_x <= (r_x == 4'd0) ? 4'(BOARD_DIM - 1) : r_x - 4'd1;
          end else if (bus.btn_right) begin
            r_x <= (r_x == 4'(BOARD_DIM - 1)) ? 4'd0 : r_x + 4'd1;
          end
        end
        S_COMMIT: begin
          if ({1'b0, r_k} == r_length - 4'd1) begin
            r_wr_en <= 1'b0;
            if (r_ship_idx == ID_W'(NUM_SHIPS - 1)) begin
              r_state      <= S_DONE;
              r_length     <= 4'd0;
              r_all_placed <= 1'b1;
            end else begin
              r_state    <= S_EDIT;
              r_ship_idx <= r_ship_idx + 1'b1;
              r_length   <= ship_len(r_ship_idx + 1'b1);
            end
          end else begin
            r_k    <= r_k + 3'd1;
            r_wr_x <= w_cx;
            r_wr_y <= w_cy;
            if (w_con) r_occ[cell_idx(w_cx, w_cy)] <= 1'b1;
          end
        end
        S_DONE: ;
      endcase
    end
  end

  assign bus.cursor      = {r_x, r_y};
  assign bus.orientation = r_orient;
  assign bus.length      = r_length;
  assign bus.fit_ok      = w_fit_ok;
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_x        = r_wr_x;
  assign bus.wr_y        = r_wr_y;
  assign bus.wr_id       = r_wr_id;
  assign bus.all_placed  = r_all_placed;

endmodule

// File: tb/tb_ship_placer.sv
// Bench for ship_placer: directed button sequences; board-store writes are
// checked by a scoreboard monitor, overlay state by direct comparisons.
module tb_ship_placer;

  logic       clk;
  logic       rst;
  logic [6:0] tb_btn;

  localparam logic [6:0] B_START  = 7'h01;
  localparam logic [6:0] B_UP     = 7'h02;
  localparam logic [6:0] B_DOWN   = 7'h04;
  localparam logic [6:0] B_LEFT   = 7'h08;
  localparam logic [6:0] B_RIGHT  = 7'h10;
  localparam logic [6:0] B_ROTATE = 7'h20;
  localparam logic [6:0] B_PLACE  = 7'h40;

  int n_chk;
  int n_fail;
  logic [10:0] sb [$];

  ship_placer_if bus ();

  assign bus.start      = tb_btn[0];
  assign bus.btn_up     = tb_btn[1];
  assign bus.btn_down   = tb_btn[2];
  assign bus.btn_left   = tb_btn[3];
  assign bus.btn_right  = tb_btn[4];
  assign bus.btn_rotate = tb_btn[5];
  assign bus.btn_place  = tb_btn[6];

  ship_placer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [6:0] m);
    @(negedge clk);
    tb_btn = m;
    @(negedge clk);
    tb_btn = 7'h00;
  endtask

  task automatic press_n(input logic [6:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic exp_wr(input int x, input int y, input int id);
    sb.push_back({4'(x), 4'(y), 3'(id)});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every write presented by the DUT must match the next
  // expected write in order; a write with nothing expected is a failure.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got x=%0d y=%0d id=%0d, required no write",
                   bus.wr_x, bus.wr_y, bus.wr_id);
        end else begin
          e = sb.pop_front();
          if ({bus.wr_x, bus.wr_y, bus.wr_id} !== e) begin
            n_fail++;
            $display("FAIL write: got x=%0d y=%0d id=%0d, required x=%0d y=%0d id=%0d",
                     bus.wr_x, bus.wr_y, bus.wr_id, e[10:7], e[6:3], e[2:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    tb_btn = 7'h00;
    rst    = 1'b1;
    wait_cyc(3);
    chk("rst_cursor", 32'(bus.cursor), 32'h00);
    chk("rst_orient", 32'(bus.orientation), 32'h1);
    chk("rst_length", 32'(bus.length), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_all_placed", 32'(bus.all_placed), 32'd0);
    chk("rst_fit", 32'(bus.fit_ok), 32'd0);
    rst = 1'b0;

    // Ship 0: N from (0,0) is off board; move to (0,4) and place.
    press(B_START);
    chk("start_cursor", 32'(bus.cursor), 32'h00);
    chk("start_orient", 32'(bus.orientation), 32'h1);
    chk("start_length", 32'(bus.length), 32'd5);
    chk("start_fit", 32'(bus.fit_ok), 32'd0);
    press_n(B_DOWN, 4);
    chk("s0_cursor", 32'(bus.cursor), 32'h04);
    chk("s0_fit", 32'(bus.fit_ok), 32'd1);
    for (int k = 0; k < 5; k++) exp_wr(0, 4 - k, 0);
    press(B_PLACE);
    wait_cyc(5);
    chk("s0_wr_done", 32'(bus.wr_en), 32'd0);
    chk("s1_length", 32'(bus.length), 32'd4);
    chk("s0_cursor_kept", 32'(bus.cursor), 32'h04);

    // Ship 1: east from (0,9).
    press(B_ROTATE);
    chk("s1_orient", 32'(bus.orientation), 32'h2);
    press_n(B_DOWN, 5);
    chk("s1_cursor", 32'(bus.cursor), 32'h09);
    chk("s1_fit", 32'(bus.fit_ok), 32'd1);
    for (int k = 0; k < 4; k++) exp_wr(k, 9, 1);
    press(B_PLACE);
    wait_cyc(4);
    chk("s2_length", 32'(bus.length), 32'd3);

    // Overlap with ship 0 at (0,4): place must be ignored.
    press_n(B_UP, 5);
    chk("ovl_cursor", 32'(bus.cursor), 32'h04);
    chk("ovl_fit", 32'(bus.fit_ok), 32'd0);
    press(B_PLACE);
    wait_cyc(3);
    chk("ovl_length", 32'(bus.length), 32'd3);
    chk("ovl_wr_en", 32'(bus.wr_en), 32'd0);

    // Left wrap 0->9; east off board, west fits.
    press(B_LEFT);
    chk("left_wrap", 32'(bus.cursor), 32'h94);
    chk("edge_e_fit", 32'(bus.fit_ok), 32'd0);
    press_n(B_ROTATE, 2);
    chk("w_orient", 32'(bus.orientation), 32'h8);
    chk("edge_w_fit", 32'(bus.fit_ok), 32'd1);
    for (int k = 0; k < 3; k++) exp_wr(9 - k, 4, 2);
    press(B_PLACE);
    wait_cyc(3);
    chk("s3_length", 32'(bus.length), 32'd3);

    // Right wrap 9->0, up wrap 0->9, down wrap 9->0.
    press(B_RIGHT);
    chk("right_wrap", 32'(bus.cursor), 32'h04);
    press(B_ROTATE);
    chk("n_orient", 32'(bus.orientation), 32'h1);
    chk("s3_ovl_fit", 32'(bus.fit_ok), 32'd0);
    press_n(B_RIGHT, 5);
    chk("s3_cursor", 32'(bus.cursor), 32'h54);
    chk("s3_fit", 32'(bus.fit_ok), 32'd1);
    press_n(B_UP, 5);
    chk("up_wrap", 32'(bus.cursor), 32'h59);
    press(B_DOWN);
    chk("down_wrap", 32'(bus.cursor), 32'h50);
    chk("n_top_fit", 32'(bus.fit_ok), 32'd0);
    press_n(B_DOWN, 2);
    chk("s3_fit2", 32'(bus.fit_ok), 32'd1);
    for (int k = 0; k < 3; k++) exp_wr(5, 2 - k, 3);
    press(B_PLACE);
    wait_cyc(3);
    chk("s4_length", 32'(bus.length), 32'd2);

    // Ship 4 with simultaneous pulses: rotate beats up, place beats right.
    chk("s4_ovl_fit", 32'(bus.fit_ok), 32'd0);
    press(B_RIGHT);
    chk("s4_fit", 32'(bus.fit_ok), 32'd1);
    press(B_ROTATE | B_UP);
    chk("prio_orient", 32'(bus.orientation), 32'h2);
    chk("prio_cursor", 32'(bus.cursor), 32'h62);
    exp_wr(6, 2, 4);
    exp_wr(7, 2, 4);
    press(B_PLACE | B_RIGHT);
    wait_cyc(2);
    chk("done_all_placed", 32'(bus.all_placed), 32'd1);
    chk("done_length", 32'(bus.length), 32'd0);
    chk("done_cursor", 32'(bus.cursor), 32'h62);

    // DONE ignores buttons.
    press(B_PLACE);
    press(B_DOWN);
    wait_cyc(2);
    chk("done_cursor2", 32'(bus.cursor), 32'h62);
    chk("done_all_placed2", 32'(bus.all_placed), 32'd1);

    // Restart from DONE clears the map.
    press(B_START);
    chk("re_length", 32'(bus.length), 32'd5);
    chk("re_all_placed", 32'(bus.all_placed), 32'd0);
    chk("re_cursor", 32'(bus.cursor), 32'h00);
    press_n(B_DOWN, 4);
    chk("re_fit", 32'(bus.fit_ok), 32'd1);

    // Reset during the second write cycle.
    exp_wr(0, 4, 0);
    exp_wr(0, 3, 0);
    press(B_PLACE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_mid_length", 32'(bus.length), 32'd0);
    chk("rst_mid_cursor", 32'(bus.cursor), 32'h00);
    rst = 1'b0;
    press(B_START);
    press_n(B_DOWN, 4);
    chk("rst_map_clear_fit", 32'(bus.fit_ok), 32'd1);

    wait_cyc(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
